// File: rtl/user_au_pkg.sv
// rtl/user_au_pkg.sv - shared audio constants and sample saturation helper
package user_au_pkg;

    localparam int SlotBits  = 32;
    localparam int FrameBits = 64;

    // Clip a signed 32-bit sample to a signed sb-bit range; result stays sign-extended.
    function automatic logic [31:0] sat_to_width(input logic [31:0] din, input int sb);
        logic signed [63:0] x;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        x  = {{32{din[31]}}, din};
        hi = (64'sd1 <<< (sb - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            sat_to_width = hi[31:0];
        end else if (x < lo) begin
            sat_to_width = lo[31:0];
        end else begin
            sat_to_width = din;
        end
    endfunction

endpackage

// File: rtl/user_au_i2s_clkgen.sv
// rtl/user_au_i2s_clkgen.sv - BCLK divider with rise/fall event strobes
module user_au_i2s_clkgen #(
    parameter int ClkDiv = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam int CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ClkDiv - 1);

    logic [CntW-1:0] cnt;
    logic            term;

    // Strobes mark the cycle whose edge toggles bclk, so dependents update alongside it.
    assign term = en && (cnt == CntMax);
    assign rise = term && !bclk;
    assign fall = term && bclk;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (term) begin
            cnt  <= '0;
            bclk <= ~bclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/user_au_i2s_tx.sv
// rtl/user_au_i2s_tx.sv - mono sample to I2S transmitter with underrun flagging
module user_au_i2s_tx
    import user_au_pkg::*;
#(
    parameter int ClkDiv     = 4,
    parameter int SampleBits = 24
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        bclk_o,
    output logic        lrclk_o,
    output logic        sd_o,
    output logic        underrun_o,
    output logic [15:0] underrun_cnt_o
);

    logic                 bclk_rise;
    logic                 bclk_fall;
    logic                 buf_full;
    logic [31:0]          buf_word;
    logic [31:0]          in_word;
    logic [FrameBits-1:0] shreg;
    logic [FrameBits-1:0] load_img;
    logic [5:0]           pos;
    logic [5:0]           pos_next;
    logic                 accept;
    logic                 load;
    logic                 starve;

    user_au_i2s_clkgen #(
        .ClkDiv(ClkDiv)
    ) u_clkgen (
        .clk (clk_i),
        .rst (rst_i),
        .en  (en_i),
        .bclk(bclk_o),
        .rise(bclk_rise),
        .fall(bclk_fall)
    );

    // Word is left-aligned in the slot so shifting MSB-first needs no per-width logic.
    assign in_word  = sat_to_width(data_i, SampleBits) << (SlotBits - SampleBits);
    assign ready_o  = !buf_full;
    assign accept   = valid_i && ready_o;
    assign pos_next = pos + 6'd1;
    assign load     = bclk_fall && (pos == 6'd63);
    assign starve   = load && !buf_full && !valid_i;

    always_comb begin
        load_img = '0;
        if (buf_full) begin
            load_img = {buf_word, buf_word};
        end else if (valid_i) begin
            load_img = {in_word, in_word};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_full <= 1'b0;
            buf_word <= '0;
        end else if (accept && !load) begin
            buf_full <= 1'b1;
            buf_word <= in_word;
        end else if (load && buf_full) begin
            buf_full <= 1'b0;
        end
    end

    // shreg holds positions 1..64; position 64 is the next frame's position 0,
    // which carries the LSB when the word fills the whole slot.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            pos     <= 6'd63;
            lrclk_o <= 1'b1;
            sd_o    <= 1'b0;
            shreg   <= '0;
        end else if (bclk_fall) begin
            pos     <= pos_next;
            lrclk_o <= pos_next[5];
            sd_o    <= shreg[FrameBits-1];
            if (load) begin
                shreg <= load_img;
            end else begin
                shreg <= shreg << 1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            underrun_o     <= 1'b0;
            underrun_cnt_o <= '0;
        end else begin
            underrun_o <= starve;
            if (starve && (underrun_cnt_o != 16'hFFFF)) begin
                underrun_cnt_o <= underrun_cnt_o + 16'd1;
            end
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) !(bclk_rise && bclk_fall));

endmodule

// File: doc/user_au_i2s_tx.md
# user_au_i2s_tx

Serialises the filtered mono sample stream onto an I2S transmit bus for the external DAC. It sits directly downstream of the low-pass cascade and accepts 32-bit signed samples over a valid/ready handshake. It saturates each sample to the DAC word width and sends it in both the left and right slots of one 64-BCLK frame. It generates BCLK and LRCLK itself from the system clock, and it flags frames that start without a sample available.

## Interface
- `ClkDiv`, default 4: `clk_i` cycles per BCLK half-period; minimum 1.
- `SampleBits`, default 24: DAC word width, range 1..32.
- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `en_i`  in  1  transmitter enable.
- `data_i`  in  32  signed input sample.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  block can accept a sample.
- `bclk_o`  out  1  I2S bit clock.
- `lrclk_o`  out  1  word select: 0 = left slot, 1 = right slot.
- `sd_o`  out  1  serial data.
- `underrun_o`  out  1  one-cycle pulse when a frame starts with no sample.
- `underrun_cnt_o`  out  16  saturating underrun counter.

## Operation
- Reset values:
  - `bclk_o`=0, `lrclk_o`=1, `sd_o`=0, `underrun_o`=0, `underrun_cnt_o`=0.
  - Buffer is empty; position counter p=63; `ready_o`=1 in the first cycle after reset.
- One-entry input buffer:
  - `ready_o` = buffer empty.
  - A transfer happens when `valid_i` && `ready_o`.
  - On acceptance the sample is saturated to `SampleBits`: values above 2^(SB-1)-1 clip to the maximum, values below -2^(SB-1) clip to the minimum, otherwise the low SB bits are kept.
- Frame format:
  - Two 32-bit slots; p counts 0..63 and wraps.
  - `lrclk_o` = (p >= 32).
  - Standard I2S one-bit delay: the word MSB is on `sd_o` at slot position 1, followed by SB bits MSB-first.
  - Remaining slot positions, including position 0 of the following slot, are 0.
  - When SB=32, the word LSB occupies position 0 of the next slot.
- Clocking:
  - The divider counts 0..ClkDiv-1 and toggles `bclk_o` at the terminal count.
  - "Fall event" is the cycle where the terminal count is reached with `bclk_o`=1.
  - On each fall event: p advances, and `lrclk_o` and `sd_o` update.
  - All three outputs (`bclk_o`, `lrclk_o`, `sd_o`) change in the same registered cycle, so data is stable at the BCLK rising edge.
- Frame load, on the fall event where p wraps 63->0:
  - Buffer full: the sample moves into the 64-bit shift register (same word in both slots) and the buffer empties.
  - Buffer empty with `valid_i` high in the same cycle: bypass. The saturated `data_i` goes straight to the shift register, the handshake completes, the buffer stays empty, and no underrun is flagged.
  - Otherwise: underrun. The frame is all zeros, `underrun_o` pulses for 1 cycle, and the counter increments, holding at 0xFFFF.
- `en_i` low:
  - Divider, p, `bclk_o`, `lrclk_o` and `sd_o` are forced to their reset values on the next edge; the shift register is cleared.
  - The buffer keeps its content and still accepts one sample.
  - Dropping `en_i` mid-frame aborts the frame immediately.
  - Raising `en_i` restarts exactly as after reset, with the first load at the first fall event.
- `rst_i` mid-frame clears everything, including a buffered sample and the counter.

## Timing
- BCLK period = 2·ClkDiv cycles; frame = 128·ClkDiv cycles.
- First fall event after reset or enable: 2·ClkDiv cycles after `en_i`=1 is sampled.
- Input-to-pin latency: at most one frame plus 1 BCLK to the MSB.
- Sustained throughput: one sample per frame. `ready_o` falls the cycle after acceptance and rises the cycle after the load.
- `valid_i` and `data_i` must stay stable until the handshake completes.

## Structure
- Put `SlotBits`=32 and `FrameBits`=64 in `user_au_pkg`, together with a `sat_to_width` function shared with other audio stages.
- Natural sub-module: `user_au_i2s_clkgen`. It holds the divider and `bclk_o` register and emits rise/fall event strobes, reset by `rst_i` or `!en_i`.
- The top level holds the buffer, the shift register, p, and the underrun logic.

## Test plan
All scenarios use ClkDiv=2 and SB=24.
- Reset and idle:
  - Hold `rst_i` 3 cycles -> all outputs at their reset values and `ready_o`=1.
  - With `en_i`=0 -> `bclk_o` stays 0 for 200 cycles.
- Basic frame:
  - Stimulus: accept 0x00123456, then `en_i`=1.
  - `bclk_o` period is 4 cycles.
  - Left slot positions 1..24 on `sd_o` = 0x123456 MSB-first, positions 25..31 = 0.
  - Right slot is identical.
  - `lrclk_o` toggles every 32 BCLK.
- Saturation:
  - 0x7FFFFFFF -> 0x7FFFFF transmitted.
  - 0x80000000 -> 0x800000 transmitted.
  - 0xFFFFFFFF -> 0xFFFFFF transmitted.
- Underrun:
  - Stimulus: no sample offered before the second frame load.
  - The second frame is all zeros, `underrun_o` is high for exactly 1 cycle, and `underrun_cnt_o`=1.
- Backpressure and bypass:
  - Offer samples A, B, C continuously -> `ready_o` low between accepts, one accept per frame boundary, and frames carry A, B, C in order.
  - With the buffer empty, assert `valid_i` only in the load cycle -> that sample is in the frame and there is no underrun.
- Abort: drop `en_i` at slot position 10 -> outputs return to reset values within 1 cycle, and the buffered sample is sent in the first frame after re-enable.
